vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture.sv | 198 +++++++++++++++++++
 tb/tb_vga_capture.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
`timescale 1ns/1ps
// vga_capture: locks onto a VGA raster (one pixel per clock) and writes one
// requested frame into a byte-wide RAM as a 1-bit-per-pixel bitmap.
// The bitmap is column-major: each byte holds 8 vertically adjacent pixels.
// Raster timing is parameterised. The defaults describe the 800x525 raster.
module vga_capture #(
    parameter int RAM_SIZE       = 8192,
    parameter int RAM_ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int XLEN           = 8,
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [3:0]                vga_red,
    input  logic [3:0]                vga_green,
    input  logic [3:0]                vga_blue,
    input  logic                      h_sync,
    input  logic                      v_sync,
    input  logic                      capture_req,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [XLEN-1:0]           ram_wdata,
    output logic [XLEN-1:0]           ram_wmask,
    output logic                      ram_we,
    output logic                      h_locked,
    output logic                      v_locked,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      capture_err
);

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_TAG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] V_TAG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [XLEN-1:0] MASK_ONE = XLEN'(1);

    typedef enum logic [1:0] {UNLOCKED = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} lock_state_t;
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2} cap_state_t;

    logic        hs_q, vs_q, pix_q;
    logic [9:0]  rx_x_q, rx_x_d, rx_y_q, rx_y_d;
    lock_state_t h_state_q, h_state_d, v_state_q, v_state_d;
    cap_state_t  cap_q;
    logic        h_locked_q, v_locked_q;
    logic        busy_q, ram_we_q, frame_done_q, capture_err_q;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, addr_calc;
    logic [XLEN-1:0] ram_wdata_q, ram_wmask_q;

    logic h_edge, v_edge, h_pred, v_pred, x_wrap;
    logic lock_ok, visible, frame_start, frame_last;

    // Edges are detected one stage early (registered level vs. pin) so that the
    // counter already carries the tag on the sample where hs_q/vs_q first read low.
    assign h_edge = hs_q & ~h_sync;
    assign v_edge = vs_q & ~v_sync;
    assign h_pred = (rx_x_q == H_TAG - 10'd1);
    assign x_wrap = ~h_edge & (rx_x_q == H_LAST);
    assign v_pred = x_wrap & (rx_y_q == V_TAG - 10'd1);

    assign lock_ok     = h_locked_q & v_locked_q;
    assign visible     = (rx_x_q < H_VIS) && (rx_y_q < V_VIS);
    assign frame_start = (rx_x_q == 10'd0) && (rx_y_q == 10'd0);
    assign frame_last  = (rx_x_q == H_VIS - 10'd1) && (rx_y_q == V_VIS - 10'd1);

    assign addr_calc = RAM_ADDR_WIDTH'(32'h0000_041F)
                     + RAM_ADDR_WIDTH'({rx_x_q, 5'd0})
                     - RAM_ADDR_WIDTH'(rx_y_q[9:3]);

    // Shared next-state rule for both axis lock FSMs.
    function automatic lock_state_t lock_next(input lock_state_t cur, input logic seen,
                                              input logic pred);
        lock_next = cur;
        case (cur)
            UNLOCKED: if (seen) lock_next = ACQUIRE;
            ACQUIRE:  if (seen && pred) lock_next = LOCKED;
            LOCKED: begin
                if (seen && !pred)      lock_next = ACQUIRE;
                else if (!seen && pred) lock_next = UNLOCKED;
            end
            default:  lock_next = UNLOCKED;
        endcase
    endfunction

    // Free-running position counters; any sync edge re-tags its axis.
    always_comb begin
        rx_x_d = (rx_x_q == H_LAST) ? 10'd0 : rx_x_q + 10'd1;
        if (h_edge) rx_x_d = H_TAG;
        rx_y_d = rx_y_q;
        if (x_wrap) rx_y_d = (rx_y_q == V_LAST) ? 10'd0 : rx_y_q + 10'd1;
        if (v_edge) rx_y_d = V_TAG;
    end

    // Lock next states; vertical lock is meaningless without horizontal lock.
    always_comb begin
        h_state_d = lock_next(h_state_q, h_edge, h_pred);
        v_state_d = (h_state_d != LOCKED) ? UNLOCKED : lock_next(v_state_q, v_edge, v_pred);
    end

    // Input sampling: syncs idle high so reset release cannot fake an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            pix_q <= 1'b0;
        end else begin
            hs_q  <= h_sync;
            vs_q  <= v_sync;
            pix_q <= |{vga_red, vga_green, vga_blue};
        end
    end

    // Position counters and both lock FSMs with registered lock flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_x_q     <= 10'd0;
            rx_y_q     <= 10'd0;
            h_state_q  <= UNLOCKED;
            v_state_q  <= UNLOCKED;
            h_locked_q <= 1'b0;
            v_locked_q <= 1'b0;
        end else begin
            rx_x_q     <= rx_x_d;
            rx_y_q     <= rx_y_d;
            h_state_q  <= h_state_d;
            v_state_q  <= v_state_d;
            h_locked_q <= (h_state_d == LOCKED);
            v_locked_q <= (v_state_d == LOCKED);
        end
    end

    // Capture FSM: writes each visible sample one cycle after it is seen.
    // busy stays high through the frame_done cycle and drops on the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q         <= IDLE;
            busy_q        <= 1'b0;
            ram_we_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            capture_err_q <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            ram_wmask_q   <= '0;
        end else begin
            ram_we_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            capture_err_q <= 1'b0;
            ram_addr_q    <= addr_calc;
            ram_wdata_q   <= {XLEN{pix_q}};
            ram_wmask_q   <= MASK_ONE << (3'd7 - rx_y_q[2:0]);
            case (cap_q)
                IDLE: begin
                    busy_q <= capture_req;
                    if (capture_req) cap_q <= ARMED;
                end
                ARMED: begin
                    if (lock_ok && frame_start) begin
                        cap_q    <= CAPTURE;
                        ram_we_q <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!lock_ok) begin
                        cap_q         <= IDLE;
                        busy_q        <= 1'b0;
                        capture_err_q <= 1'b1;
                    end else if (visible) begin
                        ram_we_q <= 1'b1;
                        if (frame_last) begin
                            cap_q        <= IDLE;
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                default: cap_q <= IDLE;
            endcase
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_wmask   = ram_wmask_q;
    assign ram_we      = ram_we_q;
    assign h_locked    = h_locked_q;
    assign v_locked    = v_locked_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign capture_err = capture_err_q;

endmodule

// File: tb/tb_vga_capture.sv
`timescale 1ns/1ps
// tb_vga_capture: directed bench on a reduced raster (32x16 visible,
// 48x24 total) so several whole frames fit in a short run.
module tb_vga_capture;

    localparam int H_ACTIVE = 32, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_ACTIVE = 16, V_FP = 2, V_SYNC = 2, V_BP = 4;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int NPIX     = H_ACTIVE * V_ACTIVE;
    localparam int AW       = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    vga_red, vga_green, vga_blue;
    logic          h_sync, v_sync, capture_req;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata, ram_wmask;
    logic          ram_we, h_locked, v_locked, busy, frame_done, capture_err;

    int tests = 0;
    int fails = 0;
    int gx, gy, shift_line = -1;
    int hs_fall_cnt = 0, vs_fall_cnt = 0;
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [31:0] first_addr = 32'd0, first_mask = 32'd0;

    vga_capture #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .h_sync(h_sync), .v_sync(v_sync), .capture_req(capture_req),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
        .ram_we(ram_we), .h_locked(h_locked), .v_locked(v_locked),
        .busy(busy), .frame_done(frame_done), .capture_err(capture_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Test picture: a few lit pixels, each lighting a different colour bit.
    function automatic logic [11:0] colour(input int x, input int y);
        if (x == 1 && y == 9)  return 12'hFFF;
        if (x == 5 && y == 3)  return 12'h001;
        if (x == 6 && y == 3)  return 12'h100;
        if (x == 20 && y == 15) return 12'h020;
        return 12'h000;
    endfunction

    function automatic logic [31:0] exp_addr(input int x, input int y);
        logic [31:0] a;
        a = 32'h41F + 32'h20 * 32'(x) - 32'(y / 8);
        return {19'd0, a[AW-1:0]};
    endfunction

    // Raster generator: one pixel per clock, pins change on the falling edge.
    initial begin : gen
        int sh;
        logic hs_new, vs_new;
        logic [11:0] col;
        gx = 0; gy = 0;
        h_sync = 1'b1; v_sync = 1'b1;
        vga_red = 4'd0; vga_green = 4'd0; vga_blue = 4'd0;
        forever begin
            @(negedge clk);
            sh = (gy == shift_line) ? 3 : 0;
            hs_new = !((gx >= H_ACTIVE + H_FP + sh) && (gx < H_ACTIVE + H_FP + H_SYNC + sh));
            vs_new = !((gy >= V_ACTIVE + V_FP) && (gy < V_ACTIVE + V_FP + V_SYNC));
            if (rst_n === 1'b1 && h_sync && !hs_new) hs_fall_cnt++;
            if (rst_n === 1'b1 && v_sync && !vs_new) vs_fall_cnt++;
            h_sync = hs_new;
            v_sync = vs_new;
            col = (gx < H_ACTIVE && gy < V_ACTIVE) ? colour(gx, gy) : 12'h000;
            {vga_red, vga_green, vga_blue} = col;
            if (gx == H_TOTAL - 1) begin
                gx = 0;
                gy = (gy == V_TOTAL - 1) ? 0 : gy + 1;
            end else begin
                gx++;
            end
        end
    end

    // Write monitor: every write is checked against raster order.
    initial begin : mon
        int ex, ey;
        forever begin
            @(negedge clk);
            if (capture_err === 1'b1) err_cnt++;
            if (frame_done === 1'b1) done_cnt++;
            if (ram_we === 1'b1) begin
                ex = wr_cnt % H_ACTIVE;
                ey = wr_cnt / H_ACTIVE;
                check("wr_addr", 32'(ram_addr), exp_addr(ex, ey));
                check("wr_mask", 32'(ram_wmask), 32'h80 >> (ey % 8));
                check("wr_data", 32'(ram_wdata), (colour(ex, ey) != 12'h000) ? 32'hFF : 32'h00);
                check("wr_done", 32'(frame_done), 32'(wr_cnt == NPIX - 1));
                check("wr_locks", 32'({h_locked, v_locked}), 32'h3);
                if (wr_cnt == 0) begin
                    first_addr = 32'(ram_addr);
                    first_mask = 32'(ram_wmask);
                end
                wr_cnt++;
            end else if (frame_done === 1'b1) begin
                check("done_without_we", 32'(ram_we), 32'h1);
            end
        end
    end

    initial begin : main
        int n, base;
        rst_n = 1'b0;
        capture_req = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_capture_err", 32'(capture_err), 0);
        check("rst_h_locked", 32'(h_locked), 0);
        check("rst_v_locked", 32'(v_locked), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_wdata", 32'(ram_wdata), 0);
        check("rst_ram_wmask", 32'(ram_wmask), 0);
        $display("[TB] step reset: outputs checked");

        // Lock acquisition: second edge of each sync locks that axis
        rst_n = 1'b1;
        n = 0; while (hs_fall_cnt < 1 && n < 2 * H_TOTAL) begin step(); n++; end
        step();
        check("h_lock_after_1st", 32'(h_locked), 0);
        n = 0; while (hs_fall_cnt < 2 && n < 2 * H_TOTAL) begin step(); n++; end
        step(); step();
        check("h_lock_after_2nd", 32'(h_locked), 1);
        n = 0; while (vs_fall_cnt < 1 && n < 2 * FRAME) begin step(); n++; end
        step();
        check("v_lock_after_1st", 32'(v_locked), 0);
        n = 0; while (vs_fall_cnt < 2 && n < 2 * FRAME) begin step(); n++; end
        step(); step();
        check("v_lock_after_2nd", 32'(v_locked), 1);
        $display("[TB] step lock: h_locked=%0b v_locked=%0b", h_locked, v_locked);

        // Request mid-frame, capture the next whole frame; a second request is ignored
        n = 0; while (gy != 5 && n < 2 * FRAME) begin step(); n++; end
        wr_cnt = 0;
        capture_req = 1'b1; step(); capture_req = 1'b0;
        check("req_busy", 32'(busy), 1);
        check("req_no_write_midframe", 32'(ram_we), 0);
        n = 0; while (wr_cnt < 10 && n < 2 * FRAME) begin step(); n++; end
        capture_req = 1'b1; step(); capture_req = 1'b0;
        n = 0; while (frame_done !== 1'b1 && n < 2 * FRAME) begin step(); n++; end
        check("frame_done_seen", 32'(frame_done), 1);
        check("done_with_write", 32'(ram_we), 1);
        check("done_busy_high", 32'(busy), 1);
        step();
        check("after_done_busy", 32'(busy), 0);
        check("after_done_pulse", 32'(frame_done), 0);
        check("write_count", 32'(wr_cnt), 32'(NPIX));
        check("first_addr", first_addr, 32'h41F);
        check("first_mask", first_mask, 32'h80);
        repeat (FRAME + 100) step();
        check("req_in_capture_ignored", 32'(wr_cnt), 32'(NPIX));
        check("idle_busy", 32'(busy), 0);
        check("done_count_1", 32'(done_cnt), 1);
        $display("[TB] step capture: %0d writes, done pulses %0d", wr_cnt, done_cnt);

        // Late hsync on line 3 of the captured frame aborts the capture
        n = 0; while (gy != V_TOTAL - 2 && n < 2 * FRAME) begin step(); n++; end
        wr_cnt = 0;
        shift_line = 3;
        capture_req = 1'b1; step(); capture_req = 1'b0;
        n = 0; while (h_locked === 1'b1 && n < 2 * FRAME) begin step(); n++; end
        check("shift_h_unlocked", 32'(h_locked), 0);
        check("shift_v_unlocked", 32'(v_locked), 0);
        check("shift_err_not_yet", 32'(capture_err), 0);
        step();
        check("err_pulse", 32'(capture_err), 1);
        check("err_busy", 32'(busy), 0);
        check("err_no_write", 32'(ram_we), 0);
        step();
        check("err_single", 32'(capture_err), 0);
        shift_line = -1;
        check("err_writes_before_abort", 32'(wr_cnt), 128);
        $display("[TB] step abort: %0d writes before abort", wr_cnt);

        // Request while unlocked: waits for relock and a frame start
        wr_cnt = 0;
        capture_req = 1'b1; step(); capture_req = 1'b0;
        check("unlocked_req_busy", 32'(busy), 1);
        n = 0; while (h_locked !== 1'b1 && n < 4 * H_TOTAL) begin step(); n++; end
        check("h_relock", 32'(h_locked), 1);
        check("v_still_unlocked", 32'(v_locked), 0);
        check("no_write_while_unlocked", 32'(wr_cnt), 0);
        n = 0; while (frame_done !== 1'b1 && n < 4 * FRAME) begin step(); n++; end
        check("relock_frame_done", 32'(frame_done), 1);
        step();
        check("relock_write_count", 32'(wr_cnt), 32'(NPIX));
        check("relock_busy", 32'(busy), 0);
        check("err_count", 32'(err_cnt), 1);
        check("done_count_2", 32'(done_cnt), 2);
        $display("[TB] step relock capture: %0d writes", wr_cnt);

        // Asynchronous reset in the middle of a capture
        n = 0; while (gy != V_TOTAL - 2 && n < 2 * FRAME) begin step(); n++; end
        wr_cnt = 0;
        capture_req = 1'b1; step(); capture_req = 1'b0;
        n = 0; while (wr_cnt < 40 && n < 2 * FRAME) begin step(); n++; end
        check("pre_reset_we", 32'(ram_we), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_we", 32'(ram_we), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_h_locked", 32'(h_locked), 0);
        check("async_rst_v_locked", 32'(v_locked), 0);
        repeat (3) step();
        rst_n = 1'b1;
        base = wr_cnt;
        repeat (3 * FRAME) step();
        check("no_write_after_reset", 32'(wr_cnt), 32'(base));
        check("post_reset_busy", 32'(busy), 0);
        check("post_reset_done_count", 32'(done_cnt), 2);
        check("post_reset_err_count", 32'(err_cnt), 1);
        check("post_reset_relock", 32'({h_locked, v_locked}), 32'h3);
        $display("[TB] step reset mid-capture: %0d writes before reset", base);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
